stream_upsizer: RTL and testbench



---
 rtl/stream_upsizer_if.sv | 40 ++++
 rtl/stream_upsizer.sv | 104 ++++++++++
 tb/tb_stream_upsizer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_upsizer_if.sv
// Valid/ready bundle for stream_upsizer: narrow input beat side and wide output word side.
// Flush-mode signals (in_last, out_cnt, out_last) exist only when UPSIZER_FLUSH_EN is defined.
interface stream_upsizer_if #(
  parameter int DATA_W = 32,
  parameter int RATIO  = 4
) ();
`ifdef UPSIZER_FLUSH_EN
  localparam int CNT_W = $clog2(RATIO + 1);
`endif

  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W*RATIO-1:0]    out_data;
`ifdef UPSIZER_FLUSH_EN
  logic                       in_last;
  logic [CNT_W-1:0]           out_cnt;
  logic                       out_last;
`endif

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
`ifdef UPSIZER_FLUSH_EN
    , input  in_last
    , output out_cnt, out_last
`endif
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
`ifdef UPSIZER_FLUSH_EN
    , output in_last
    , input  out_cnt, out_last
`endif
  );
endinterface

// File: rtl/stream_upsizer.sv
// Packs RATIO consecutive DATA_W-bit beats into one registered DATA_W*RATIO-bit word, lane 0 first.
// Optional UPSIZER_FLUSH_EN: in_last closes a word early, reporting out_cnt and out_last.
module stream_upsizer #(
  parameter int DATA_W = 32,
  parameter int RATIO  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  stream_upsizer_if.slave   bus
);
  localparam int IDX_W  = $clog2(RATIO);
  localparam int WORD_W = DATA_W * RATIO;
  localparam int ACC_W  = DATA_W * (RATIO - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);
`ifdef UPSIZER_FLUSH_EN
  localparam int CNT_W = $clog2(RATIO + 1);
`endif

  logic [IDX_W-1:0]   idx_r;
  logic [ACC_W-1:0]   acc_r;
  logic               out_full_r;
  logic [WORD_W-1:0]  out_data_r;
`ifdef UPSIZER_FLUSH_EN
  logic [CNT_W-1:0]   out_cnt_r;
  logic               out_last_r;
`endif

  logic               last_term_s;
  logic               in_ready_s;
  logic               accept_s;
  logic               complete_s;
  logic [WORD_W-1:0]  word_s;

`ifdef UPSIZER_FLUSH_EN
  assign last_term_s = bus.in_last;
`else
  assign last_term_s = 1'b0;
`endif

  // Stall input only when the next beat would complete a word that has nowhere to go.
  assign in_ready_s = ((idx_r != IDX_LAST) && !last_term_s) || !out_full_r || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign complete_s = accept_s && ((idx_r == IDX_LAST) || last_term_s);

  // Assemble the completed word: collected lanes below idx, incoming beat at idx, zeros above.
  always_comb begin
    word_s = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (IDX_W'(k) < idx_r) begin
        word_s[k*DATA_W +: DATA_W] = acc_r[k*DATA_W +: DATA_W];
      end else begin
        word_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end
    end
    word_s[int'(idx_r)*DATA_W +: DATA_W] = bus.in_data;
  end

  // Lane counter, assembly buffer and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r      <= '0;
      acc_r      <= '0;
      out_full_r <= 1'b0;
      out_data_r <= '0;
`ifdef UPSIZER_FLUSH_EN
      out_cnt_r  <= '0;
      out_last_r <= 1'b0;
`endif
    end else begin
      if (complete_s) begin
        // The output register is free or draining this edge, so it can load directly.
        out_data_r <= word_s;
        out_full_r <= 1'b1;
        idx_r      <= '0;
        acc_r      <= '0;
`ifdef UPSIZER_FLUSH_EN
        out_cnt_r  <= CNT_W'(idx_r) + CNT_W'(1);
        out_last_r <= last_term_s;
`endif
      end else begin
        if (accept_s) begin
          acc_r[int'(idx_r)*DATA_W +: DATA_W] <= bus.in_data;
          idx_r <= idx_r + IDX_W'(1);
        end else begin
          idx_r <= idx_r;
        end
        if (out_full_r && bus.out_ready) begin
          out_full_r <= 1'b0;
        end else begin
          out_full_r <= out_full_r;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_full_r;
  assign bus.out_data  = out_data_r;
`ifdef UPSIZER_FLUSH_EN
  assign bus.out_cnt   = out_cnt_r;
  assign bus.out_last  = out_last_r;
`endif

endmodule

// File: tb/tb_stream_upsizer.sv
// Scoreboard bench for stream_upsizer (DATA_W=32, RATIO=4); flush cases run when UPSIZER_FLUSH_EN is defined.
module tb_stream_upsizer;
  localparam int DATA_W = 32;
  localparam int RATIO  = 4;
  localparam int WORD_W = DATA_W * RATIO;
  localparam int CNT_W  = 3;

  typedef struct {
    logic [WORD_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
    logic              last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   acc_cnt = 0;
  int   cyc = 0;
  exp_t sb[$];

  stream_upsizer_if #(.DATA_W(DATA_W), .RATIO(RATIO)) bus ();

  stream_upsizer #(.DATA_W(DATA_W), .RATIO(RATIO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [WORD_W-1:0] d, input logic [CNT_W-1:0] c, input logic l);
    exp_t e;
    e.data = d;
    e.cnt  = c;
    e.last = l;
    sb.push_back(e);
  endtask

  // Monitor: pop and compare every word the DUT hands off; count accepted input beats.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", bus.out_data, {WORD_W{1'b0}});
        if (bus.out_data === {WORD_W{1'b0}}) begin
          failures++;
          $display("FAIL unexpected_word actual=%h expected=none", bus.out_data);
        end
      end else begin
        e = sb.pop_front();
        chk("out_data", bus.out_data, e.data);
`ifdef UPSIZER_FLUSH_EN
        chk("out_cnt", WORD_W'(bus.out_cnt), WORD_W'(e.cnt));
        chk("out_last", WORD_W'(bus.out_last), WORD_W'(e.last));
`endif
      end
    end
    if (rst_n && bus.in_valid && bus.in_ready) acc_cnt++;
  end

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
`ifdef UPSIZER_FLUSH_EN
    bus.in_last = 1'b0;
`endif
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low expected=accept_within_50");
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
`ifdef UPSIZER_FLUSH_EN
    bus.in_last  = 1'b0;
`endif
    wait_accept();
  endtask

`ifdef UPSIZER_FLUSH_EN
  task automatic send_last(input logic [DATA_W-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = 1'b1;
    wait_accept();
  endtask
`endif

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("sb_drained", WORD_W'(sb.size()), {WORD_W{1'b0}});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WORD_W-1:0] w;
    int c0;
    int a0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
`ifdef UPSIZER_FLUSH_EN
    bus.in_last   = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", WORD_W'(bus.out_valid), {WORD_W{1'b0}});
    chk("rst_out_data", bus.out_data, {WORD_W{1'b0}});
    chk("rst_in_ready", WORD_W'(bus.in_ready), WORD_W'(1'b1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", WORD_W'(bus.in_ready), WORD_W'(1'b1));
    @(posedge clk);
    #1;

    // Back-to-back word with out_ready high; out_valid lasts one cycle
    push(128'h00000044_00000033_00000022_00000011, 3'd4, 1'b0);
    send(32'h11);
    send(32'h22);
    send(32'h33);
    send(32'h44);
    @(negedge clk);
    chk("t1_valid_rise", WORD_W'(bus.out_valid), WORD_W'(1'b1));
    @(negedge clk);
    chk("t1_valid_fall", WORD_W'(bus.out_valid), {WORD_W{1'b0}});
    @(posedge clk);
    #1;

    // Output stalled: three more beats accepted, fourth blocked until drain
    bus.out_ready = 1'b0;
    push(128'h000000A4_000000A3_000000A2_000000A1, 3'd4, 1'b0);
    push(128'h000000B4_000000B3_000000B2_000000B1, 3'd4, 1'b0);
    send(32'hA1);
    send(32'hA2);
    send(32'hA3);
    send(32'hA4);
    send(32'hB1);
    send(32'hB2);
    send(32'hB3);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hB4;
    @(negedge clk);
    chk("stall_in_ready", WORD_W'(bus.in_ready), {WORD_W{1'b0}});
    chk("stall_out_valid", WORD_W'(bus.out_valid), WORD_W'(1'b1));
    chk("stall_hold_data", bus.out_data, 128'h000000A4_000000A3_000000A2_000000A1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall_in_ready2", WORD_W'(bus.in_ready), {WORD_W{1'b0}});
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("drain_in_ready", WORD_W'(bus.in_ready), WORD_W'(1'b1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("next_word_valid", WORD_W'(bus.out_valid), WORD_W'(1'b1));
    drain();

    // Continuous stream: 8 words, beat = {word, lane}
    for (int wi = 0; wi < 8; wi++) begin
      w = '0;
      for (int k = 0; k < RATIO; k++) w[k*DATA_W +: DATA_W] = {16'h0000, 8'(wi), 8'(k)};
      push(w, 3'd4, 1'b0);
    end
    c0 = cyc;
    a0 = acc_cnt;
    for (int wi = 0; wi < 8; wi++) begin
      for (int k = 0; k < RATIO; k++) send({16'h0000, 8'(wi), 8'(k)});
    end
    chk("stream_cycles", WORD_W'(cyc - c0), WORD_W'(32));
    chk("stream_accepts", WORD_W'(acc_cnt - a0), WORD_W'(32));
    drain();

`ifdef UPSIZER_FLUSH_EN
    // Early flush by in_last
    push(128'h00000000_00000000_0000000B_0000000A, 3'd2, 1'b1);
    push(128'h00000000_00000000_00000000_0000000C, 3'd1, 1'b1);
    push(128'h00000F4_000000F3_000000F2_000000F1 | 128'h0, 3'd4, 1'b1);
    send(32'hA);
    send_last(32'hB);
    send_last(32'hC);
    send(32'hF1);
    send(32'hF2);
    send(32'hF3);
    send_last(32'hF4);
    drain();
`endif

    // Reset mid-word discards the partial beats
    send(32'hD1);
    send(32'hD2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", WORD_W'(bus.out_valid), {WORD_W{1'b0}});
    chk("midrst_in_ready", WORD_W'(bus.in_ready), WORD_W'(1'b1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(128'h000000E4_000000E3_000000E2_000000E1, 3'd4, 1'b0);
    send(32'hE1);
    send(32'hE2);
    send(32'hE3);
    send(32'hE4);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
